div_sequencer: RTL

Controller between the execute stage and the iterative divider. It accepts DIV/DIVU/REM/REMU requests and returns divide-by-zero and signed-overflow results directly. It also returns repeated identical operations from a one-entry result cache. All other requests are issued to the divider, with the pipeline stalled until the result is returned. It honours the global cache stall and pipeline flush.

---
 rtl/div_sequencer_if.sv | 36 +++
 rtl/div_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/div_sequencer_if.sv
// Handshake bundle between execute, div_sequencer and the iterative divider.
interface div_sequencer_if #(
    parameter int D_WIDTH = 32
);
    logic               cache_stall;
    logic               flush;
    logic               req_valid;
    logic [1:0]         req_ctrl;
    logic [D_WIDTH-1:0] req_op1;
    logic [D_WIDTH-1:0] req_op2;
    logic [4:0]         req_rd;
    logic               stall;
    logic               resp_valid;
    logic [D_WIDTH-1:0] resp_data;
    logic [4:0]         resp_rd;
    logic               dv_start;
    logic [1:0]         dv_ctrl;
    logic [D_WIDTH-1:0] dv_op1;
    logic [D_WIDTH-1:0] dv_op2;
    logic               dv_done;
    logic [D_WIDTH-1:0] dv_result;

    modport slave (
        input  cache_stall, flush, req_valid, req_ctrl,
        input  req_op1, req_op2, req_rd, dv_done, dv_result,
        output stall, resp_valid, resp_data, resp_rd,
        output dv_start, dv_ctrl, dv_op1, dv_op2
    );

    modport master (
        output cache_stall, flush, req_valid, req_ctrl,
        output req_op1, req_op2, req_rd, dv_done, dv_result,
        input  stall, resp_valid, resp_data, resp_rd,
        input  dv_start, dv_ctrl, dv_op1, dv_op2
    );
endinterface

// File: rtl/div_sequencer.sv
// Divide request sequencer: fast-paths div-by-zero, overflow and repeats,
// otherwise runs the iterative divider with the pipeline stalled.
module div_sequencer #(
    parameter int D_WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    div_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, RESP, DRAIN
    } state_t;

    localparam logic [D_WIDTH-1:0] MIN_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

    state_t             state;
    state_t             next_state;
    logic [1:0]         ctrl_q;
    logic [D_WIDTH-1:0] op1_q;
    logic [D_WIDTH-1:0] op2_q;
    logic [4:0]         rd_q;
    logic [D_WIDTH-1:0] data_q;
    logic               c_valid;
    logic [1:0]         c_ctrl;
    logic [D_WIDTH-1:0] c_op1;
    logic [D_WIDTH-1:0] c_op2;
    logic [D_WIDTH-1:0] c_res;

    logic               accept;
    logic               zero;
    logic               ovf;
    logic               hit;
    logic               fast;
    logic [D_WIDTH-1:0] fast_res;
    logic               cache_wr;

    assign accept = (state == IDLE) & bus.req_valid
                  & ~bus.cache_stall & ~bus.flush;
    assign zero = (bus.req_op2 == '0);
    assign ovf  = ~bus.req_ctrl[0] & (bus.req_op1 == MIN_NEG)
                & (bus.req_op2 == '1);
    assign hit  = c_valid & (c_ctrl == bus.req_ctrl)
                & (c_op1 == bus.req_op1) & (c_op2 == bus.req_op2);
    assign fast = zero | ovf | hit;
    assign cache_wr = (state == WAIT) & bus.dv_done & ~bus.flush;

    // Zero divisor outranks overflow, both outrank a cache hit.
    always_comb begin
        fast_res = c_res;
        unique case (1'b1)
            zero:    fast_res = bus.req_ctrl[1] ? bus.req_op1 : '1;
            ovf:     fast_res = bus.req_ctrl[1] ? '0 : MIN_NEG;
            default: fast_res = c_res;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (accept) next_state = fast ? RESP : ISSUE;
            ISSUE: next_state = bus.flush ? IDLE : WAIT;
            WAIT: begin
                if (bus.flush)        next_state = bus.dv_done ? IDLE : DRAIN;
                else if (bus.dv_done) next_state = RESP;
            end
            RESP:  next_state = (bus.cache_stall & ~bus.flush) ? RESP : IDLE;
            DRAIN: if (bus.dv_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Front end stays frozen until the result is presented; a flush or
    // a drain releases it immediately.
    always_comb begin
        bus.stall      = bus.req_valid & ~bus.flush
                       & (state != RESP) & (state != DRAIN);
        bus.resp_valid = (state == RESP) & ~bus.flush;
        bus.dv_start   = (state == ISSUE) & ~bus.flush;
    end

    assign bus.resp_data = data_q;
    assign bus.resp_rd   = rd_q;
    assign bus.dv_ctrl   = ctrl_q;
    assign bus.dv_op1    = op1_q;
    assign bus.dv_op2    = op2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            c_valid <= 1'b0;
            c_ctrl  <= '0;
            c_op1   <= '0;
            c_op2   <= '0;
            c_res   <= '0;
        end else begin
            if (accept) begin
                ctrl_q <= bus.req_ctrl;
                op1_q  <= bus.req_op1;
                op2_q  <= bus.req_op2;
                rd_q   <= bus.req_rd;
                if (fast) data_q <= fast_res;
            end
            if (cache_wr) begin
                data_q  <= bus.dv_result;
                c_valid <= 1'b1;
                c_ctrl  <= ctrl_q;
                c_op1   <= op1_q;
                c_op2   <= op2_q;
                c_res   <= bus.dv_result;
            end
        end
    end
endmodule
